// File: rtl/score_pkg.sv
// Shared widths, FSM state encoding and request mode for the high-score keeper.
package score_pkg;

  localparam int SCORE_W = 8;
  localparam int ADDR_W  = 3;
  localparam int BCD_W   = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_CONVERT = 3'd4;
  localparam logic [2:0] ST_SHOW    = 3'd5;

  typedef enum logic {
    MODE_GAME = 1'b0,
    MODE_SHOW = 1'b1
  } mode_t;

endpackage

// File: rtl/high_score_keeper_bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per cycle.
module bin2bcd8
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output logic [BCD_W-1:0]   hund,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones
);

  localparam int SR_W = 3 * BCD_W + SCORE_W;

  logic [SR_W-1:0] sr;
  logic [3:0]      steps;

  function automatic logic [SR_W-1:0] shift_add3(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int d = 0; d < 3; d++) begin
      if (t[SCORE_W + BCD_W*d +: BCD_W] >= 4'd5)
        t[SCORE_W + BCD_W*d +: BCD_W] = t[SCORE_W + BCD_W*d +: BCD_W] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr    <= '0;
      steps <= '0;
    end else if (start) begin
      sr    <= {{(3*BCD_W){1'b0}}, bin};
      steps <= 4'(SCORE_W);
    end else if (steps != 4'd0) begin
      sr    <= shift_add3(sr);
      steps <= steps - 4'd1;
    end
  end

  // Asserted during the cycle whose closing edge performs the final step.
  assign done = (steps == 4'd1);
  assign hund = sr[SR_W-1 -: BCD_W];
  assign tens = sr[SR_W-1-BCD_W -: BCD_W];
  assign ones = sr[SR_W-1-2*BCD_W -: BCD_W];

endmodule

// File: rtl/high_score_keeper.sv
// Per-user high-score keeper: reads the stored best, writes a beaten record back
// to the score RAM, and shows the resulting value as three BCD digits.
module high_score_keeper
  import score_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int MAX_SCORE = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  user_idx,
  input  logic               game_done,
  input  logic [SCORE_W-1:0] player_score,
  input  logic [1:0]         multiplier,
  input  logic               show_btn,
  input  logic [SCORE_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [SCORE_W-1:0] ram_wdata,
  output logic               ram_we,
  output logic               busy,
  output logic               new_record,
  output logic [BCD_W-1:0]   bcd_hund,
  output logic [BCD_W-1:0]   bcd_tens,
  output logic [BCD_W-1:0]   bcd_ones,
  output logic               disp_valid
);

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  logic [2:0]         state;
  logic [1:0]         rd_cnt;
  mode_t              mode;
  logic [SCORE_W-1:0] scaled;
  logic [SCORE_W-1:0] stored;
  logic               accept;
  logic               take_write;
  logic               conv_start;
  logic               conv_done;
  logic [SCORE_W-1:0] conv_value;

  function automatic logic [SCORE_W-1:0] sat_scale(input logic [SCORE_W-1:0] s,
                                                   input logic [1:0] m);
    logic [9:0] p;
    p = 10'(s) * (10'(m) + 10'd1);
    if (p > 10'(MAX_SCORE))
      return SCORE_W'(MAX_SCORE);
    return p[SCORE_W-1:0];
  endfunction

  assign accept     = ((state == ST_IDLE) || (state == ST_SHOW)) && (game_done || show_btn);
  assign take_write = (mode == MODE_GAME) && (scaled > stored);
  assign conv_start = ((state == ST_COMPARE) && !take_write) || (state == ST_WRITE);
  // Picks max(scaled, stored) for a game and stored for a show request.
  assign conv_value = take_write ? scaled : stored;

  assign ram_we    = (state == ST_WRITE);
  assign ram_wdata = ram_we ? scaled : '0;
  assign busy      = !((state == ST_IDLE) || (state == ST_SHOW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rd_cnt     <= '0;
      mode       <= MODE_GAME;
      scaled     <= '0;
      stored     <= '0;
      ram_addr   <= '0;
      new_record <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (accept) begin
            state      <= ST_RD_WAIT;
            rd_cnt     <= '0;
            ram_addr   <= user_idx;
            mode       <= game_done ? MODE_GAME : MODE_SHOW;
            disp_valid <= 1'b0;
            new_record <= 1'b0;
            if (game_done)
              scaled <= sat_scale(player_score, multiplier);
          end
        end
        ST_RD_WAIT: begin
          if (rd_cnt == RD_LAST) begin
            stored <= ram_rdata;
            state  <= ST_COMPARE;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        ST_COMPARE: begin
          if (take_write) begin
            state      <= ST_WRITE;
            new_record <= 1'b1;
          end else begin
            state <= ST_CONVERT;
          end
        end
        ST_WRITE:   state <= ST_CONVERT;
        ST_CONVERT: begin
          if (conv_done) begin
            state      <= ST_SHOW;
            disp_valid <= 1'b1;
          end
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

  bin2bcd8 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_value),
    .done  (conv_done),
    .hund  (bcd_hund),
    .tens  (bcd_tens),
    .ones  (bcd_ones)
  );

endmodule

// File: tb/tb_high_score_keeper.sv
// Bench for high_score_keeper: fixed vector table, reset corner cases and random
// requests checked against an arithmetic model with its own copy of the score RAM.
module tb_high_score_keeper;
  import score_pkg::*;

  localparam int RD_LAT    = 2;
  localparam int MAX_SCORE = 255;
  localparam int PIPE_IDX  = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] user_idx = '0;
  logic       game_done = 1'b0;
  logic [7:0] player_score = '0;
  logic [1:0] multiplier = '0;
  logic       show_btn = 1'b0;
  logic [7:0] ram_rdata;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we, busy, new_record, disp_valid;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;

  always #5 clk = ~clk;

  high_score_keeper #(.RD_LAT(RD_LAT), .MAX_SCORE(MAX_SCORE)) dut (
    .clk(clk), .rst(rst), .user_idx(user_idx), .game_done(game_done),
    .player_score(player_score), .multiplier(multiplier), .show_btn(show_btn),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .new_record(new_record), .bcd_hund(bcd_hund), .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones), .disp_valid(disp_valid)
  );

  // Score RAM with RD_LAT-cycle read latency; preload port used only by the bench.
  logic [7:0] mem [8];
  logic [2:0] apipe [3];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  int         we_cnt = 0, wr_addr = 0, wr_data = 0;

  always @(posedge clk) begin
    apipe[0] <= ram_addr;
    apipe[1] <= apipe[0];
    apipe[2] <= apipe[1];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt  <= we_cnt + 1;
      wr_addr <= int'(ram_addr);
      wr_data <= int'(ram_wdata);
    end
  end

  always_comb ram_rdata = (RD_LAT == 1) ? mem[ram_addr] : mem[apipe[PIPE_IDX]];

  int passed = 0, total = 0;
  int mmem [8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic preload(input int a, input int d);
    pl_en = 1'b1; pl_addr = 3'(a); pl_data = 8'(d);
    @(posedge clk); #1;
    pl_en = 1'b0;
    mmem[a] = d;
  endtask

  task automatic run_req(input int game, input int show, input int u, input int score,
                         input int mult, input int inject, input int ewe, input int ewd,
                         input int enr, input int eh, input int et, input int eo,
                         input string tag);
    int we0, cyc;
    we0 = we_cnt;
    game_done = game[0]; show_btn = show[0];
    user_idx = 3'(u); player_score = 8'(score); multiplier = 2'(mult);
    @(posedge clk); #1;
    game_done = 1'b0; show_btn = 1'b0;
    check({tag, ".busy"}, int'(busy), 1);
    check({tag, ".dv_clr"}, int'(disp_valid), 0);
    check({tag, ".nr_clr"}, int'(new_record), 0);
    check({tag, ".addr"}, int'(ram_addr), u);
    user_idx = 3'($urandom); player_score = 8'($urandom); multiplier = 2'($urandom);
    cyc = 0;
    while (!disp_valid && cyc < 60) begin
      @(posedge clk); cyc++; #1;
      if (inject != 0 && cyc == RD_LAT + 3) begin
        game_done = 1'b1; player_score = 8'd255; multiplier = 2'd3; user_idx = 3'(u);
      end else begin
        game_done = 1'b0;
      end
    end
    game_done = 1'b0;
    check({tag, ".latency"}, cyc, RD_LAT + 9 + ewe);
    check({tag, ".we_cnt"}, we_cnt - we0, ewe);
    if (ewe != 0) begin
      check({tag, ".wr_addr"}, wr_addr, u);
      check({tag, ".wr_data"}, wr_data, ewd);
    end
    check({tag, ".new_record"}, int'(new_record), enr);
    check({tag, ".bcd"}, int'({bcd_hund, bcd_tens, bcd_ones}), (eh << 8) | (et << 4) | eo);
    check({tag, ".idle"}, int'(busy), 0);
    repeat (3) begin @(posedge clk); #1; end
    check({tag, ".hold"}, int'({disp_valid, bcd_hund, bcd_tens, bcd_ones}),
          (1 << 12) | (eh << 8) | (et << 4) | eo);
  endtask

  typedef struct {
    int pl_en, pl_addr, pl_val, game, show, u, score, mult, inject, we, wdata, nr, h, t, o;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int we0, cyc, kind, g, s, u, sc, mu, st, w, v;

    vecs[0]  = '{1, 2,  40, 1, 0, 2,  30, 1, 0, 1,  60, 1, 0, 6, 0};
    vecs[1]  = '{1, 5, 200, 1, 0, 5, 100, 3, 0, 1, 255, 1, 2, 5, 5};
    vecs[2]  = '{1, 1,  90, 1, 0, 1,  90, 0, 0, 0,   0, 0, 0, 9, 0};
    vecs[3]  = '{1, 4, 137, 0, 1, 4,   0, 0, 1, 0,   0, 0, 1, 3, 7};
    vecs[4]  = '{0, 0,   0, 1, 1, 2, 100, 0, 0, 1, 100, 1, 1, 0, 0};
    vecs[5]  = '{0, 0,   0, 1, 0, 5, 255, 3, 0, 0,   0, 0, 2, 5, 5};
    vecs[6]  = '{0, 0,   0, 0, 1, 2,   0, 0, 0, 0,   0, 0, 1, 0, 0};
    vecs[7]  = '{0, 0,   0, 1, 0, 2,  10, 2, 0, 0,   0, 0, 1, 0, 0};
    vecs[8]  = '{0, 0,   0, 1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0,   0, 1, 0, 7,   1, 0, 0, 1,   1, 1, 0, 0, 1};
    vecs[10] = '{0, 0,   0, 1, 0, 3,  99, 1, 0, 1, 198, 1, 1, 9, 8};

    #1;
    check("rst.outputs", int'({ram_we, ram_addr, ram_wdata, busy, new_record, disp_valid,
                               bcd_hund, bcd_tens, bcd_ones}), 0);
    for (int i = 0; i < 8; i++) preload(i, 0);
    check("rst.held", int'({ram_we, busy, disp_valid, bcd_hund, bcd_tens, bcd_ones}), 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pl_en != 0) preload(vecs[i].pl_addr, vecs[i].pl_val);
      run_req(vecs[i].game, vecs[i].show, vecs[i].u, vecs[i].score, vecs[i].mult,
              vecs[i].inject, vecs[i].we, vecs[i].wdata, vecs[i].nr,
              vecs[i].h, vecs[i].t, vecs[i].o, $sformatf("vec%0d", i));
      if (vecs[i].we != 0) mmem[vecs[i].u] = vecs[i].wdata;
    end

    // Reset asserted while WRITE is active: ram_we must fall without a clock edge.
    we0 = we_cnt;
    game_done = 1'b1; user_idx = 3'd6; player_score = 8'd200; multiplier = 2'd0;
    @(posedge clk); #1;
    game_done = 1'b0;
    cyc = 0;
    while (!ram_we && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("rstw.we_seen", int'(ram_we), 1);
    #2 rst = 1'b0;
    #1;
    check("rstw.we_drop", int'(ram_we), 0);
    check("rstw.outputs", int'({ram_addr, ram_wdata, busy, new_record, disp_valid,
                                bcd_hund, bcd_tens, bcd_ones}), 0);
    @(posedge clk); #1;
    check("rstw.no_write", we_cnt - we0, 0);
    @(negedge clk);
    rst = 1'b1;
    run_req(1, 0, 6, 5, 0, 0, 1, 5, 1, 0, 0, 5, "rstw.first");
    mmem[6] = 5;

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      g  = (kind != 0) ? 1 : 0;
      s  = (kind == 0 || kind == 3) ? 1 : 0;
      u  = $urandom_range(0, 7);
      sc = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      mu = $urandom_range(0, 3);
      st = mmem[u];
      w  = 0;
      v  = st;
      if (g != 0) begin
        v = sc * (mu + 1);
        if (v > MAX_SCORE) v = MAX_SCORE;
        if (v > st) w = 1;
        else v = st;
      end
      run_req(g, s, u, sc, mu, 0, w, v, w, v / 100, (v / 10) % 10, v % 10,
              $sformatf("rnd%0d", n));
      if (w != 0) mmem[u] = v;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
